// File: rtl/operand_tile_buffer.sv
// Ping-pong operand tile buffer feeding the 2x2 systolic array operand muxes.
// Optional sticky overflow flag: define OPBUF_OVF_EN.
//
// Ports:
//   clk, rst                  clock and sync active-high reset
//   flush                     discard all buffered and partial tiles
//   in_valid/in_data/in_ready host byte stream, 8 bytes per tile (w0..w3, x0..x3)
//   tile_valid/tile_take      read bank holds a full tile / release it
//   a0_sel,a1_sel,b0_sel,b1_sel,transpose  operand routing from control unit
//   a0,a1,b0,b1               signed operands, zero when no tile is valid
//   ovf_err                   sticky drop flag (tied low unless OPBUF_OVF_EN)
module operand_tile_buffer #(
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     in_ready,
    output logic                     tile_valid,
    input  logic                     tile_take,
    input  logic [1:0]               a0_sel,
    input  logic [1:0]               a1_sel,
    input  logic [1:0]               b0_sel,
    input  logic [1:0]               b1_sel,
    input  logic                     transpose,
    output logic signed [DATA_W-1:0] a0,
    output logic signed [DATA_W-1:0] a1,
    output logic signed [DATA_W-1:0] b0,
    output logic signed [DATA_W-1:0] b1,
    output logic                     ovf_err
);

    logic [DATA_W-1:0] r_bank [0:1][0:7];
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [2:0]        r_wr_ptr;
    logic [1:0]        r_full;

    logic              w_accept;
    logic              w_release;
    logic              w_last;
    logic [1:0]        w_full_nxt;

    assign in_ready   = !r_full[r_wr_bank];
    assign tile_valid = r_full[r_rd_bank];
    assign w_accept   = in_valid && in_ready;
    assign w_release  = tile_take && tile_valid;
    assign w_last     = (r_wr_ptr == 3'd7);

    // Write and read banks never coincide while both events fire,
    // so set and clear can be applied independently.
    always_comb begin
        w_full_nxt = r_full;
        if (w_accept && w_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_release) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_ptr  <= 3'd0;
            r_full    <= 2'b00;
        end else begin
            r_full <= w_full_nxt;
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 3'd1;
                if (w_last) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    // Bank storage is never cleared; validity is tracked by r_full only.
    always_ff @(posedge clk) begin
        if (w_accept && !rst && !flush) begin
            r_bank[r_wr_bank][r_wr_ptr] <= in_data;
        end
    end

    logic [DATA_W-1:0] w_w0, w_w1, w_w2, w_w3;
    logic [DATA_W-1:0] w_x0, w_x1, w_x2, w_x3;

    assign w_w0 = r_bank[r_rd_bank][0];
    assign w_w1 = r_bank[r_rd_bank][1];
    assign w_w2 = r_bank[r_rd_bank][2];
    assign w_w3 = r_bank[r_rd_bank][3];
    assign w_x0 = r_bank[r_rd_bank][4];
    assign w_x1 = r_bank[r_rd_bank][5];
    assign w_x2 = r_bank[r_rd_bank][6];
    assign w_x3 = r_bank[r_rd_bank][7];

    always_comb begin
        a0 = '0;
        a1 = '0;
        b0 = '0;
        b1 = '0;
        if (tile_valid) begin
            case (a0_sel)
                2'd0:    a0 = w_w0;
                2'd1:    a0 = w_w1;
                default: a0 = '0;
            endcase
            case (a1_sel)
                2'd0:    a1 = w_w2;
                2'd1:    a1 = w_w3;
                default: a1 = '0;
            endcase
            // transpose swaps which of x1/x2 reaches each column
            case (b0_sel)
                2'd0:    b0 = w_x0;
                2'd1:    b0 = transpose ? w_x2 : w_x1;
                default: b0 = '0;
            endcase
            case (b1_sel)
                2'd0:    b1 = transpose ? w_x1 : w_x2;
                2'd1:    b1 = w_x3;
                default: b1 = '0;
            endcase
        end
    end

`ifdef OPBUF_OVF_EN
    logic r_ovf_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_err <= 1'b0;
        end else if (in_valid && !in_ready && !flush) begin
            r_ovf_err <= 1'b1;
        end
    end

    assign ovf_err = r_ovf_err;
`else
    assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_operand_tile_buffer.sv
// Directed self-checking bench for operand_tile_buffer.
// Expected values are hand-computed from the tile contents streamed in.
module tb_operand_tile_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       tile_valid;
    logic       tile_take;
    logic [1:0] a0_sel, a1_sel, b0_sel, b1_sel;
    logic       transpose;
    logic [7:0] a0, a1, b0, b1;
    logic       ovf_err;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef OPBUF_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    operand_tile_buffer #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .tile_valid(tile_valid),
        .tile_take (tile_take),
        .a0_sel    (a0_sel),
        .a1_sel    (a1_sel),
        .b0_sel    (b0_sel),
        .b1_sel    (b1_sel),
        .transpose (transpose),
        .a0        (a0),
        .a1        (a1),
        .b0        (b0),
        .b1        (b1),
        .ovf_err   (ovf_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic sels(input logic [1:0] s0, s1, s2, s3, input logic tr);
        a0_sel = s0; a1_sel = s1; b0_sel = s2; b1_sel = s3;
        transpose = tr;
        #1;
    endtask

    task automatic ops(input string tag, input logic [7:0] e0, e1, e2, e3);
        chk({tag, ".a0"}, {24'd0, a0}, {24'd0, e0});
        chk({tag, ".a1"}, {24'd0, a1}, {24'd0, e1});
        chk({tag, ".b0"}, {24'd0, b0}, {24'd0, e2});
        chk({tag, ".b1"}, {24'd0, b1}, {24'd0, e3});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        tile_take = 1'b0;
        a0_sel = 0; a1_sel = 0; b0_sel = 0; b1_sel = 0; transpose = 0;
        #2;
        do_reset();

        // 1: reset state, single tile
        chk("rst.in_ready", in_ready, 1);
        chk("rst.tile_valid", tile_valid, 0);
        chk("rst.ovf", ovf_err, 0);
        ops("rst", 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) push(8'(i));
        chk("t1.valid_early", tile_valid, 0);
        push(8'd8);
        chk("t1.tile_valid", tile_valid, 1);
        sels(0, 0, 0, 0, 0);
        ops("t1.s0", 1, 3, 5, 7);
        sels(1, 1, 1, 1, 0);
        ops("t1.s1", 2, 4, 6, 8);

        // 2: transpose and zero selects
        sels(0, 0, 1, 0, 1);
        chk("t2.b0", {24'd0, b0}, 7);
        chk("t2.b1", {24'd0, b1}, 6);
        sels(2, 3, 2, 3, 0);
        ops("t2.zero", 0, 0, 0, 0);

        // 3: both banks full, drop, release
        do_reset();
        for (int i = 9; i <= 24; i++) push(8'(i));
        chk("t3.in_ready", in_ready, 0);
        chk("t3.tile_valid", tile_valid, 1);
        push(8'd25);
        chk("t3.ovf", ovf_err, OVF_EXP);
        sels(0, 0, 0, 0, 0);
        ops("t3.tileA", 9, 11, 13, 15);
        tile_take = 1'b1;
        tick();
        tile_take = 1'b0;
        chk("t3.in_ready_after", in_ready, 1);
        chk("t3.valid_after", tile_valid, 1);
        ops("t3.tileB", 17, 19, 21, 23);

        // 4: 8th byte of new tile with simultaneous take
        for (int i = 31; i <= 37; i++) push(8'(i));
        in_valid = 1'b1; in_data = 8'd38; tile_take = 1'b1;
        tick();
        in_valid = 1'b0; tile_take = 1'b0;
        chk("t4.tile_valid", tile_valid, 1);
        chk("t4.in_ready", in_ready, 1);
        ops("t4.s0", 31, 33, 35, 37);
        sels(1, 1, 1, 1, 0);
        ops("t4.s1", 32, 34, 36, 38);
        for (int i = 40; i <= 47; i++) push(8'(i));
        chk("t4.both_full", in_ready, 0);
        tile_take = 1'b1;
        tick();
        tile_take = 1'b0;
        sels(0, 0, 0, 0, 0);
        ops("t4.idx0", 40, 42, 44, 46);

        // 5: flush mid-load with same-cycle byte and take
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h99; tile_take = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; tile_take = 1'b0;
        chk("t5.tile_valid", tile_valid, 0);
        chk("t5.in_ready", in_ready, 1);
        chk("t5.ovf_kept", ovf_err, OVF_EXP);
        ops("t5.zero", 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) push(8'(8'h80 + i));
        chk("t5.tile_valid2", tile_valid, 1);
        ops("t5.s0", 8'h80, 8'h82, 8'h84, 8'h86);

        // 6: spurious take ignored, reset mid-load
        tile_take = 1'b1;
        tick();
        chk("t6.released", tile_valid, 0);
        tick();
        tile_take = 1'b0;
        chk("t6.ignored", tile_valid, 0);
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        chk("t6.valid", tile_valid, 1);
        ops("t6.s0", 8'h10, 8'h12, 8'h14, 8'h16);
        for (int i = 0; i < 3; i++) push(8'(8'h50 + i));
        do_reset();
        chk("t6.rst.in_ready", in_ready, 1);
        chk("t6.rst.tile_valid", tile_valid, 0);
        chk("t6.rst.ovf", ovf_err, 0);
        ops("t6.rst", 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
        sels(1, 1, 1, 1, 1);
        ops("t6.after", 8'h21, 8'h23, 8'h26, 8'h27);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
